dino_jump_ctrl: RTL and testbench

DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

---
 rtl/dino_jump_ctrl_pkg.sv | 33 +++
 rtl/dino_jump_ctrl.sv | 122 ++++++++++++
 tb/tb_dino_jump_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dino_jump_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dino_jump_ctrl_pkg : shared encodings and physics defaults for the dino jump.
// Revision: 1.0
// ---------------------------------------------------------------------------
package dino_jump_ctrl_pkg;

   localparam logic [1:0] GS_IDLE = 2'b00;
   localparam logic [1:0] GS_OVER = 2'b01;
   localparam logic [1:0] GS_PLAY = 2'b10;

   localparam int DEF_JUMP_VEL = 16;
   localparam int DEF_GRAVITY  = 1;

   localparam logic [1:0] ST_GROUND_ENC = 2'd0;
   localparam logic [1:0] ST_RISE_ENC   = 2'd1;
   localparam logic [1:0] ST_FALL_ENC   = 2'd2;

   typedef enum logic [1:0] {
      ST_GROUND = ST_GROUND_ENC,
      ST_RISE   = ST_RISE_ENC,
      ST_FALL   = ST_FALL_ENC
   } dino_state_e;

   // Saturating 8-bit add; the parameter range keeps the peak in range anyway.
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {4'd0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/dino_jump_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dino_jump_ctrl : ground/rise/fall jump FSM with integer physics per frame tick.
// Revision: 1.0
// ---------------------------------------------------------------------------
module dino_jump_ctrl
   import dino_jump_ctrl_pkg::*;
#(
   parameter int JUMP_VEL = DEF_JUMP_VEL,
   parameter int GRAVITY  = DEF_GRAVITY
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic [1:0] game_state,
   input  logic       jump_btn,
   input  logic       duck_btn,
   output logic       airborne,
   output logic       on_ground,
   output logic       is_duck,
   output logic [7:0] height,
   output logic       jump_start
);

   localparam logic [4:0] VEL_INIT = 5'(JUMP_VEL);
   localparam logic [4:0] GRAV     = 5'(GRAVITY);

   dino_state_e state;
   dino_state_e state_nxt;
   dino_state_e state_upd;
   logic [4:0]  vel;
   logic [4:0]  vel_nxt;
   logic [7:0]  height_nxt;
   logic        launch;
   logic [5:0]  fall_vel;

   // One extra bit so the falling speed can never wrap before the landing test.
   assign fall_vel = {1'b0, vel} + {1'b0, GRAV};

   always_comb begin
      state_nxt  = state;
      vel_nxt    = vel;
      height_nxt = height;
      launch     = 1'b0;
      case (state)
         ST_GROUND: begin
            if (jump_btn && !duck_btn) begin
               state_nxt = ST_RISE;
               vel_nxt   = VEL_INIT;
               launch    = 1'b1;
            end
         end
         ST_RISE: begin
            height_nxt = sat_add8(height, vel);
            if (vel <= GRAV) begin
               state_nxt = ST_FALL;
               vel_nxt   = 5'd0;
            end else begin
               vel_nxt = vel - GRAV;
            end
         end
         ST_FALL: begin
            if ({2'b00, fall_vel} >= height) begin
               state_nxt  = ST_GROUND;
               vel_nxt    = 5'd0;
               height_nxt = 8'd0;
            end else begin
               height_nxt = height - {2'b00, fall_vel};
               vel_nxt    = fall_vel[5] ? 5'h1F : fall_vel[4:0];
            end
         end
         default: begin
            state_nxt  = ST_GROUND;
            vel_nxt    = 5'd0;
            height_nxt = 8'd0;
         end
      endcase
   end

   // Pose outputs track the state as it will stand after this edge.
   assign state_upd = frame_tick ? state_nxt : state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_GROUND;
         vel        <= 5'd0;
         height     <= 8'd0;
         airborne   <= 1'b0;
         on_ground  <= 1'b1;
         is_duck    <= 1'b0;
         jump_start <= 1'b0;
      end else begin
         case (game_state)
            GS_PLAY: begin
               if (frame_tick) begin
                  state  <= state_nxt;
                  vel    <= vel_nxt;
                  height <= height_nxt;
               end
               airborne   <= (state_upd != ST_GROUND);
               on_ground  <= (state_upd == ST_GROUND);
               is_duck    <= (state_upd == ST_GROUND) && duck_btn;
               jump_start <= frame_tick && launch;
            end
            GS_OVER: begin
               jump_start <= 1'b0;
            end
            default: begin
               state      <= ST_GROUND;
               vel        <= 5'd0;
               height     <= 8'd0;
               airborne   <= 1'b0;
               on_ground  <= 1'b1;
               is_duck    <= 1'b0;
               jump_start <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dino_jump_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dino_jump_ctrl : directed and randomized checks against a jump-profile model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dino_jump_ctrl;

   localparam int JV = 16;
   localparam int GR = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_tick;
   logic [1:0] game_state;
   logic       jump_btn;
   logic       duck_btn;
   logic       airborne;
   logic       on_ground;
   logic       is_duck;
   logic [7:0] height;
   logic       jump_start;

   always #5 clk = ~clk;

   dino_jump_ctrl #(.JUMP_VEL(JV), .GRAVITY(GR)) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .game_state (game_state),
      .jump_btn   (jump_btn),
      .duck_btn   (duck_btn),
      .airborne   (airborne),
      .on_ground  (on_ground),
      .is_duck    (is_duck),
      .height     (height),
      .jump_start (jump_start)
   );

   int vectors    = 0;
   int miscompares = 0;

   // Model: a jump is a fixed height table indexed by ticks since launch.
   int prof[0:63];
   int jlen;
   int m_phase = 0;
   bit m_duck  = 1'b0;
   bit m_js    = 1'b0;
   bit model_on = 1'b0;

   function automatic void build_profile();
      int h, v, nv, p;
      bit rising;
      for (int i = 0; i < 64; i++) prof[i] = 0;
      h = 0; v = JV; rising = 1'b1; p = 1; jlen = 63;
      while (p < 63) begin
         p++;
         if (rising) begin
            h = h + v;
            if (v <= GR) begin rising = 1'b0; v = 0; end
            else v = v - GR;
            prof[p] = h;
         end else begin
            nv = v + GR;
            if (h <= nv) begin prof[p] = 0; jlen = p; break; end
            h = h - nv; v = nv; prof[p] = h;
         end
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_duck = 1'b0; m_js = 1'b0;
      end else if (game_state == 2'b10) begin
         m_js = 1'b0;
         if (frame_tick) begin
            if (m_phase == 0) begin
               if (jump_btn && !duck_btn) begin m_phase = 1; m_js = 1'b1; end
            end else begin
               m_phase++;
               if (m_phase >= jlen) m_phase = 0;
            end
         end
         m_duck = (m_phase == 0) && duck_btn;
      end else if (game_state == 2'b01) begin
         m_js = 1'b0;
      end else begin
         m_phase = 0; m_duck = 1'b0; m_js = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         vectors++;
         if (airborne !== (m_phase != 0) || on_ground !== (m_phase == 0) ||
             is_duck !== m_duck || height !== 8'(prof[m_phase]) || jump_start !== m_js) begin
            miscompares++;
            $display("FAIL cycle_check t=%0t: got air=%0b gnd=%0b duck=%0b h=%0d js=%0b, want air=%0b gnd=%0b duck=%0b h=%0d js=%0b",
                     $time, airborne, on_ground, is_duck, height, jump_start,
                     (m_phase != 0), (m_phase == 0), m_duck, prof[m_phase], m_js);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input bit ft);
      frame_tick = ft;
      @(posedge clk);
      #2;
      frame_tick = 1'b0;
   endtask

   task automatic tick();
      cyc(1'b1);
      cyc(1'b0);
   endtask

   initial begin
      int pulses, second;
      rst = 1'b1; game_state = 2'b00; frame_tick = 1'b0; jump_btn = 1'b0; duck_btn = 1'b0;
      build_profile();
      check("prof_len", jlen, 33);
      check("prof_t2", prof[2], 16);
      check("prof_t3", prof[3], 31);
      check("prof_peak", prof[17], 136);

      repeat (3) @(posedge clk);
      #2;
      model_on = 1'b1;
      check("rst_height", height, 0);
      check("rst_on_ground", on_ground, 1);
      check("rst_airborne", airborne, 0);
      check("rst_jump_start", jump_start, 0);
      rst = 1'b0; game_state = 2'b10;

      // Single jump, ticks on every other clk
      jump_btn = 1'b1; cyc(1'b1);
      check("launch_js", jump_start, 1);
      check("launch_h", height, 0);
      check("launch_air", airborne, 1);
      jump_btn = 1'b0; cyc(1'b0);
      check("js_one_cycle", jump_start, 0);
      for (int t = 2; t <= 33; t++) begin
         tick();
         if (t == 3)  check("rise_t3", height, 31);
         if (t == 17) check("peak_t17", height, 136);
         if (t == 32) check("t32_air", airborne, 1);
      end
      check("land_h", height, 0);
      check("land_gnd", on_ground, 1);

      // Duck overrides jump
      jump_btn = 1'b1; duck_btn = 1'b1;
      repeat (5) tick();
      check("duck_pose", is_duck, 1);
      check("duck_h", height, 0);
      check("duck_gnd", on_ground, 1);
      jump_btn = 1'b0; duck_btn = 1'b0; cyc(1'b0);
      check("duck_release", is_duck, 0);

      // Freeze mid-rise
      jump_btn = 1'b1; tick(); jump_btn = 1'b0; tick(); tick();
      check("pre_over_h", height, 31);
      game_state = 2'b01;
      repeat (10) cyc(1'b1);
      check("over_h", height, 31);
      check("over_air", airborne, 1);
      game_state = 2'b10;
      tick(); check("resume_h1", height, 45);
      tick(); check("resume_h2", height, 58);
      repeat (30) tick();
      check("resume_land", on_ground, 1);

      // IDLE mid-fall
      jump_btn = 1'b1; tick(); jump_btn = 1'b0;
      repeat (21) tick();
      check("fall_air", airborne, 1);
      game_state = 2'b00; cyc(1'b0);
      check("idle_h", height, 0);
      check("idle_gnd", on_ground, 1);
      game_state = 2'b10;

      // Reset at the peak, then a clean jump
      jump_btn = 1'b1; tick(); jump_btn = 1'b0;
      repeat (16) tick();
      check("peak_before_rst", height, 136);
      rst = 1'b1; cyc(1'b1); rst = 1'b0;
      check("rst_peak_h", height, 0);
      check("rst_peak_gnd", on_ground, 1);
      jump_btn = 1'b1; tick(); jump_btn = 1'b0;
      repeat (32) tick();
      check("rejump_land", on_ground, 1);

      // Held jump relaunches after every landing
      jump_btn = 1'b1; pulses = 0; second = 0;
      for (int t = 1; t <= 67; t++) begin
         cyc(1'b1);
         if (jump_start) begin
            pulses++;
            if (pulses == 2) second = t;
         end
         cyc(1'b0);
      end
      check("relaunch_cnt", pulses, 3);
      check("relaunch_tick", second, 34);
      jump_btn = 1'b0;
      repeat (40) tick();

      // Randomized play
      for (int i = 0; i < 4000; i++) begin
         int r;
         rst = ($urandom % 300) == 0;
         if (($urandom % 40) == 0) begin
            r = $urandom % 16;
            game_state = (r < 11) ? 2'b10 : (r < 13) ? 2'b01 : (r < 15) ? 2'b00 : 2'b11;
         end
         jump_btn = ($urandom % 3) != 0;
         duck_btn = ($urandom % 5) == 0;
         cyc(($urandom % 3) == 0);
      end
      rst = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
